// File: rtl/imm_enc.sv
// imm_enc: instruction encoder, the inverse of the core's immediate generator.
// Decoded fields and a full 32-bit immediate are accepted over a valid/ready
// handshake, scattered into RV32I bit positions selected by immSel, and the
// packed word leaves through a 2-entry output FIFO.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload until the transfer. ready never
// depends on valid in the same cycle. in_ready and out_valid come from FIFO
// state only, so there is no combinational path from input to output.
//
// Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that do not
// fit the selected format. Without it, err/err_sticky are tied low and
// immediates are silently truncated.
module imm_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  immSel,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        err,
  output logic        err_sticky,
  output logic [15:0] enc_cnt
);

  // Shared immediate-format codes; every other code encodes an R-type word.
  localparam logic [2:0] ImmSel_I = 3'd1;
  localparam logic [2:0] ImmSel_S = 3'd2;
  localparam logic [2:0] ImmSel_B = 3'd3;
  localparam logic [2:0] ImmSel_U = 3'd4;
  localparam logic [2:0] ImmSel_J = 3'd5;

  logic [31:0] packed_word;
  logic        push;
  logic        pop;

  // FIFO storage and pointers
  logic [31:0] mem [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;

  // Scatter the immediate into the bit positions of the selected format.
  always_comb begin
    packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
    case (immSel)
      ImmSel_I: packed_word = {imm[11:0], rs1, funct3, rd, opcode};
      ImmSel_S: packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      ImmSel_B: packed_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], opcode};
      ImmSel_U: packed_word = {imm[31:12], rd, opcode};
      ImmSel_J: packed_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                               rd, opcode};
      default:  packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
    endcase
  end

  // Occupancy-only flow control keeps in_ready independent of out_ready.
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head word is forced to zero while the FIFO is empty so stale data never shows.
  assign inst = out_valid ? mem[head] : 32'd0;

  // FIFO storage, pointers, occupancy and the popped-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= 32'd0;
      mem[1]  <= 32'd0;
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
      enc_cnt <= 16'd0;
    end else begin
      if (push) begin
        mem[tail] <= packed_word;
        tail      <= ~tail;
      end
      if (pop) begin
        head    <= ~head;
        enc_cnt <= enc_cnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic       range_err;
  logic [1:0] err_mem;

  // An immediate is out of range when bits above the field are not a pure
  // sign extension, or when a branch/jump offset is odd, or a U value has low bits.
  always_comb begin
    range_err = 1'b0;
    case (immSel)
      ImmSel_I, ImmSel_S:
        range_err = !((&imm[31:11]) || !(|imm[31:11]));
      ImmSel_B:
        range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      ImmSel_J:
        range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      ImmSel_U:
        range_err = |imm[11:0];
      default:
        range_err = 1'b0;
    endcase
  end

  // Per-entry error flag travels with its word; the sticky flag only clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_mem    <= 2'b00;
      err_sticky <= 1'b0;
    end else if (push) begin
      err_mem[tail] <= range_err;
      if (range_err) begin
        err_sticky <= 1'b1;
      end
    end
  end

  assign err = out_valid && err_mem[head];
`else
  assign err        = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// tb_imm_enc: scoreboard bench for imm_enc. Each accepted input pushes its
// fields onto exp_q; each popped output word is checked against the head
// entry by field position and by a round-trip immediate decode.
`timescale 1ns/1ps
module tb_imm_enc;

  localparam logic [2:0] SEL_R = 3'd0;
  localparam logic [2:0] SEL_I = 3'd1;
  localparam logic [2:0] SEL_S = 3'd2;
  localparam logic [2:0] SEL_B = 3'd3;
  localparam logic [2:0] SEL_U = 3'd4;
  localparam logic [2:0] SEL_J = 3'd5;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        in_range;
    logic        exp_err;
    logic        has_word;
    logic [31:0] word;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  immSel;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        err;
  logic        err_sticky;
  logic [15:0] enc_cnt;

  txn_t        exp_q[$];
  txn_t        cur;
  int          n_checks;
  int          n_errors;
  int          pops_model;
  logic        sticky_model;

  imm_enc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .immSel     (immSel),
    .imm        (imm),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inst       (inst),
    .err        (err),
    .err_sticky (err_sticky),
    .enc_cnt    (enc_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Out-of-range means the immediate is not the sign extension of its field width.
  function automatic logic violates(input logic [2:0] sel, input logic [31:0] v);
    case (sel)
      SEL_I, SEL_S: return {{20{v[11]}}, v[11:0]} != v;
      SEL_B:        return ({{19{v[12]}}, v[12:0]} != v) || v[0];
      SEL_J:        return ({{11{v[20]}}, v[20:0]} != v) || v[0];
      SEL_U:        return v[11:0] != 12'd0;
      default:      return 1'b0;
    endcase
  endfunction

  // Reference immediate generator used for the round-trip decode.
  function automatic logic [31:0] dec_imm(input logic [2:0] sel, input logic [31:0] i);
    case (sel)
      SEL_I:   return {{20{i[31]}}, i[31:20]};
      SEL_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      SEL_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      SEL_U:   return {i[31:12], 12'd0};
      SEL_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic txn_t mk(input logic [2:0] sel, input logic [31:0] v,
                              input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic hw, input logic [31:0] w);
    txn_t t;
    t.sel      = sel;
    t.imm      = v;
    t.opcode   = op;
    t.rd       = d;
    t.rs1      = s1;
    t.rs2      = s2;
    t.funct3   = f3;
    t.funct7   = f7;
    t.in_range = !violates(sel, v);
`ifdef IMM_RANGE_CHECK_EN
    t.exp_err  = violates(sel, v);
`else
    t.exp_err  = 1'b0;
`endif
    t.has_word = hw;
    t.word     = w;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    logic [2:0]  sel;
    logic [31:0] r;
    logic [31:0] v;
    sel = 3'($urandom_range(0, 7));
    r   = $urandom();
    case (sel)
      SEL_I, SEL_S: v = {{20{r[11]}}, r[11:0]};
      SEL_B:        v = {{19{r[12]}}, r[12:1], 1'b0};
      SEL_J:        v = {{11{r[20]}}, r[20:1], 1'b0};
      SEL_U:        v = {r[31:12], 12'd0};
      default:      v = r;
    endcase
    return mk(sel, v, 7'($urandom()), 5'($urandom()), 5'($urandom()),
              5'($urandom()), 3'($urandom()), 7'($urandom()), 1'b0, 32'd0);
  endfunction

  // driver tasks
  task automatic apply(input txn_t t);
    cur    = t;
    immSel = t.sel;
    imm    = t.imm;
    opcode = t.opcode;
    rd     = t.rd;
    rs1    = t.rs1;
    rs2    = t.rs2;
    funct3 = t.funct3;
    funct7 = t.funct7;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input txn_t t);
    logic acc;
    int   n;
    apply(t);
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic verify(input txn_t t);
    check("opcode", inst[6:0], t.opcode);
    case (t.sel)
      SEL_I: begin
        check("rd", inst[11:7], t.rd);
        check("funct3", inst[14:12], t.funct3);
        check("rs1", inst[19:15], t.rs1);
      end
      SEL_S, SEL_B: begin
        check("funct3", inst[14:12], t.funct3);
        check("rs1", inst[19:15], t.rs1);
        check("rs2", inst[24:20], t.rs2);
      end
      SEL_U, SEL_J: check("rd", inst[11:7], t.rd);
      default: begin
        check("rd", inst[11:7], t.rd);
        check("funct3", inst[14:12], t.funct3);
        check("rs1", inst[19:15], t.rs1);
        check("rs2", inst[24:20], t.rs2);
        check("funct7", inst[31:25], t.funct7);
      end
    endcase
    if (t.sel inside {SEL_I, SEL_S, SEL_B, SEL_U, SEL_J} && t.in_range)
      check("imm_roundtrip", dec_imm(t.sel, inst), t.imm);
    if (t.has_word) check("inst_word", inst, t.word);
    check("err", err, t.exp_err);
  endtask

  // scoreboard: checks flow state each cycle, pops on output transfer, pushes on accept
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, exp_q.size() < 2);
      check("enc_cnt", enc_cnt, 32'(pops_model[15:0]));
      check("err_sticky", err_sticky, sticky_model);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_pop", 32'd1, 32'd0);
        end else begin
          verify(exp_q.pop_front());
          pops_model++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur);
        sticky_model = sticky_model | cur.exp_err;
      end
    end
  end

  initial begin
    int base;
    logic exp_sticky;
    n_checks     = 0;
    n_errors     = 0;
    pops_model   = 0;
    sticky_model = 1'b0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    apply(mk(SEL_R, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 32'd0));
    #12;
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_enc_cnt", enc_cnt, 32'd0);
    check("rst_err", err, 32'd0);
    check("rst_err_sticky", err_sticky, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // I-type addi x1, x0, 5 with one-cycle latency
    send(mk(SEL_I, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h0050_0093));
    check("lat_out_valid", out_valid, 32'd1);
    check("lat_inst", inst, 32'h0050_0093);
    @(posedge clk);
    #1;
    check("enc_cnt_first", enc_cnt, 32'd1);

    // B, J, U directed words back to back
    send(mk(SEL_B, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 1'b1, 32'hFE20_8EE3));
    send(mk(SEL_J, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h0010_00EF));
    send(mk(SEL_U, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h1234_52B7));
    drain();

    // backpressure: two accepts fill the FIFO, third waits for the first pop
    out_ready = 1'b0;
    send(mk(SEL_I, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h0050_0093));
    send(mk(SEL_J, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h0010_00EF));
    apply(mk(SEL_U, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h1234_52B7));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", in_ready, 32'd0);
      check("bp_head_hold", inst, 32'h0050_0093);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_first_pop", in_ready, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_ready_after_pop", in_ready, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // range-check stimulus: truncated words, err follows the build option
    send(mk(SEL_I, 32'd2048, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 1'b1, 32'h8001_8113));
    send(mk(SEL_B, 32'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 1'b1, 32'h0020_8163));
    drain();
`ifdef IMM_RANGE_CHECK_EN
    exp_sticky = 1'b1;
`else
    exp_sticky = 1'b0;
`endif
    @(posedge clk);
    #1;
    check("sticky_after_range", err_sticky, exp_sticky);

    // simultaneous push and pop at occupancy 1
    send(rand_txn());
    base = pops_model;
    for (int i = 0; i < 10; i++) begin
      check("burst_out_valid", out_valid, 32'd1);
      check("burst_in_ready", in_ready, 32'd1);
      send(rand_txn());
    end
    check("burst_enc_cnt", enc_cnt, 32'(16'(base + 10)));
    drain();

    // reset mid-stream with two words queued
    out_ready = 1'b0;
    send(rand_txn());
    send(rand_txn());
    apply(rand_txn());
    in_valid = 1'b1;
    check("pre_rst_out_valid", out_valid, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 32'd0);
    check("mid_rst_in_ready", in_ready, 32'd1);
    check("mid_rst_inst", inst, 32'd0);
    check("mid_rst_enc_cnt", enc_cnt, 32'd0);
    check("mid_rst_err", err, 32'd0);
    check("mid_rst_err_sticky", err_sticky, 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    pops_model   = 0;
    sticky_model = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // randomized round-trip stream long enough to wrap enc_cnt
    for (int i = 0; i < 65537; i++) begin
      send(rand_txn());
    end
    drain();
    check("enc_cnt_wrap", enc_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
